mpu_matrix_loader: RTL and testbench

- Sequential front end for the determinant unit, and the writer side of its packed-matrix interface.
- Accepts a stream of signed 8-bit elements in row-major order from the MPU data path over a valid/ready handshake.
- Assembles them into the packed 5x5 matrix bus, zero-padding unused cells, and presents the matrix with its size.
- The determinant unit consumes matrix + size combinationally whenever matrix_valid is high.

---
 rtl/mpu_pkg.sv | 22 ++
 rtl/mpu_rc_counter.sv | 53 +++++
 rtl/mpu_matrix_loader.sv | 120 ++++++++++++
 tb/tb_mpu_matrix_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared constants, state encoding and the packed-matrix element offset
// used by the MPU matrix loader and its companions.
package mpu_pkg;

  localparam int MPU_MAX_N    = 5;
  localparam int MPU_ELEM_W   = 8;
  localparam int MPU_MATRIX_W = MPU_ELEM_W * MPU_MAX_N * MPU_MAX_N;
  localparam int MPU_IDX_W    = $clog2(MPU_MAX_N);
  localparam int MPU_CNT_W    = $clog2(MPU_MAX_N * MPU_MAX_N + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } mpu_state_e;

  // Bit offset of element (r,c) on the ascending-range packed bus.
  function automatic int offset(input int r, input int c);
    return MPU_ELEM_W * (c + MPU_MAX_N * r);
  endfunction

endpackage

// File: rtl/mpu_rc_counter.sv
// Row/column/element tracker for row-major traversal of an NxN matrix.
// Shared by the matrix loader and the future matrix serializer.
module mpu_rc_counter
  import mpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_step,
  input  logic [MPU_IDX_W-1:0] i_n,
  output logic [MPU_IDX_W-1:0] o_row,
  output logic [MPU_IDX_W-1:0] o_col,
  output logic [MPU_CNT_W-1:0] o_count,
  output logic                 o_last
);

  logic [MPU_IDX_W-1:0] r_row;
  logic [MPU_IDX_W-1:0] r_col;
  logic [MPU_CNT_W-1:0] r_count;
  logic [MPU_IDX_W-1:0] w_n_m1;
  logic                 w_col_end;

  assign w_n_m1    = i_n - MPU_IDX_W'(1);
  assign w_col_end = (r_col == w_n_m1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row   <= '0;
      r_col   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_row   <= '0;
      r_col   <= '0;
      r_count <= '0;
    end else if (i_step) begin
      r_count <= r_count + MPU_CNT_W'(1);
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + MPU_IDX_W'(1);
      end else begin
        r_col <= r_col + MPU_IDX_W'(1);
      end
    end
  end

  assign o_row   = r_row;
  assign o_col   = r_col;
  assign o_count = r_count;
  assign o_last  = w_col_end && (r_row == w_n_m1);

endmodule

// File: rtl/mpu_matrix_loader.sv
// Streams row-major signed elements into the packed 5x5 matrix bus consumed
// combinationally by the determinant unit, with size and valid qualifiers.
module mpu_matrix_loader
  import mpu_pkg::*;
#(
  parameter int MAX_N  = MPU_MAX_N,
  parameter int ELEM_W = MPU_ELEM_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic signed [7:0]          size,
  input  logic                       abort,
  input  logic signed [ELEM_W-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [0:ELEM_W*MAX_N*MAX_N-1] matrix,
  output logic [7:0]                 matrix_size,
  output logic                       matrix_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [MPU_CNT_W-1:0]       count
);

  localparam logic signed [7:0] L_MAX_N = 8'(MAX_N);

  mpu_state_e r_state, w_next_state;

  logic [0:ELEM_W*MAX_N*MAX_N-1] r_matrix;
  logic [7:0]                    r_matrix_size;
  logic                          r_matrix_valid;
  logic                          r_error;

  logic                 w_legal;
  logic                 w_start_ok;
  logic                 w_start_bad;
  logic                 w_take;
  logic                 w_clear;
  logic                 w_last;
  logic [MPU_IDX_W-1:0] w_row;
  logic [MPU_IDX_W-1:0] w_col;
  int                   w_off;

  assign w_legal     = (size >= 8'sd1) && (size <= L_MAX_N);
  assign w_start_ok  = (r_state == IDLE) && start && w_legal;
  assign w_start_bad = (r_state == IDLE) && start && !w_legal;
  // Abort outranks a simultaneous beat, including the final one.
  assign w_take      = (r_state == LOAD) && in_valid && !abort;
  assign w_clear     = w_start_ok || ((r_state == LOAD) && abort);
  assign w_off       = offset(int'(w_row), int'(w_col));

  mpu_rc_counter u_rc_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_step  (w_take),
    .i_n     (r_matrix_size[MPU_IDX_W-1:0]),
    .o_row   (w_row),
    .o_col   (w_col),
    .o_count (count),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: if (w_start_ok) w_next_state = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort)                w_next_state = IDLE;
        else if (w_take && w_last) w_next_state = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: the matrix storage is deliberately reset; the determinant unit reads
  // it combinationally, so it must be defined zeros from reset onward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_matrix       <= '0;
      r_matrix_size  <= '0;
      r_matrix_valid <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_error <= w_start_bad;
      if (w_start_ok) begin
        r_matrix       <= '0;
        r_matrix_size  <= size;
        r_matrix_valid <= 1'b0;
      end else if (w_take) begin
        r_matrix[w_off +: ELEM_W] <= in_data;
        if (w_last) r_matrix_valid <= 1'b1;
      end
      if (abort) r_matrix_valid <= 1'b0;
    end
  end

  assign matrix       = r_matrix;
  assign matrix_size  = r_matrix_size;
  assign matrix_valid = r_matrix_valid;
  assign error        = r_error;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed self-checking bench for mpu_matrix_loader: legal loads, backpressure,
// illegal sizes, abort, mid-load reset and start-while-busy.
module tb_mpu_matrix_loader;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic signed [7:0] size;
  logic              abort;
  logic signed [7:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [0:199]      matrix;
  logic [7:0]        matrix_size;
  logic              matrix_valid;
  logic              busy;
  logic              done;
  logic              error;
  logic [4:0]        count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mpu_matrix_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .size         (size),
    .abort        (abort),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .matrix       (matrix),
    .matrix_size  (matrix_size),
    .matrix_valid (matrix_valid),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .count        (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] elem(input int r, input int c);
    int off;
    off = 8 * (c + 5 * r);
    return matrix[off +: 8];
  endfunction

  // Number of nonzero bytes outside the top-left n x n block.
  function automatic int outside_nonzero(input int n);
    int k;
    k = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if ((r >= n || c >= n) && elem(r, c) != 8'h00) k++;
    return k;
  endfunction

  function automatic int det2();
    return int'($signed(elem(0, 0))) * int'($signed(elem(1, 1)))
         - int'($signed(elem(0, 1))) * int'($signed(elem(1, 0)));
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic do_start(input logic signed [7:0] s);
    start = 1'b1;
    size  = s;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic signed [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic signed [7:0] bad_sizes [3];
    int sent;
    int done_cnt;
    int cyc;

    rst_n = 1'b0; start = 1'b0; size = '0; abort = 1'b0;
    in_data = '0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", matrix_valid, 0);
    check("rst_count", count, 0);
    check("rst_matrix_zero", matrix == '0, 1);
    rst_n = 1'b1;
    idle_cycle();

    // 2x2: 3 -1 / 4 2, det = 10
    do_start(8'sd2);
    check("2x2_in_ready", in_ready, 1);
    check("2x2_busy", busy, 1);
    beat(8'sd3);
    beat(-8'sd1);
    beat(8'sd4);
    check("2x2_not_done_early", done, 0);
    beat(8'sd2);
    check("2x2_done", done, 1);
    check("2x2_valid", matrix_valid, 1);
    check("2x2_ready_in_done", in_ready, 0);
    check("2x2_size", matrix_size, 2);
    check("2x2_count", count, 4);
    check("2x2_e00", elem(0, 0), 8'h03);
    check("2x2_e01", elem(0, 1), 8'hFF);
    check("2x2_e10_off40", matrix[40 +: 8], 8'h04);
    check("2x2_e11", elem(1, 1), 8'h02);
    check("2x2_pad_zero", outside_nonzero(2), 0);
    check("2x2_det", det2(), 10);
    idle_cycle();
    check("2x2_done_one_cycle", done, 0);
    check("2x2_valid_held", matrix_valid, 1);

    // 5x5 with in_valid toggling every other cycle
    do_start(8'sd5);
    check("5x5_valid_cleared", matrix_valid, 0);
    sent = 0; done_cnt = 0; cyc = 0;
    while (done_cnt == 0 && cyc < 200) begin
      if (sent < 25 && (cyc % 2 == 0)) begin
        in_valid = 1'b1;
        in_data  = 8'(sent + 1);
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done) begin
        done_cnt++;
        check("5x5_ready_in_done", in_ready, 0);
      end
    end
    in_valid = 1'b0;
    check("5x5_done_seen", done_cnt, 1);
    check("5x5_count", count, 25);
    check("5x5_e44_off192", matrix[192 +: 8], 8'd25);
    check("5x5_e23", elem(2, 3), 8'd14);
    check("5x5_e00", elem(0, 0), 8'd1);
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      if (done) done_cnt++;
    end
    check("5x5_done_once", done_cnt, 1);

    // Illegal sizes leave the held 5x5 untouched
    bad_sizes[0] = 8'sd0; bad_sizes[1] = 8'sd6; bad_sizes[2] = -8'sd3;
    for (int i = 0; i < 3; i++) begin
      do_start(bad_sizes[i]);
      check($sformatf("bad%0d_error", i), error, 1);
      check($sformatf("bad%0d_ready", i), in_ready, 0);
      check($sformatf("bad%0d_busy", i), busy, 0);
      check($sformatf("bad%0d_valid", i), matrix_valid, 1);
      check($sformatf("bad%0d_size", i), matrix_size, 5);
      idle_cycle();
      check($sformatf("bad%0d_error_pulse", i), error, 0);
    end
    check("bad_e44_kept", elem(4, 4), 8'd25);

    // Abort a 3x3 after 4 beats
    do_start(8'sd3);
    beat(8'sd10); beat(8'sd20); beat(8'sd30); beat(8'sd40);
    check("abort_pre_count", count, 4);
    abort = 1'b1;
    idle_cycle();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", matrix_valid, 0);
    check("abort_count", count, 0);
    check("abort_no_done", done, 0);
    idle_cycle();
    check("abort_no_done_later", done, 0);
    do_start(8'sd1);
    beat(8'sd7);
    check("n1_done", done, 1);
    check("n1_valid", matrix_valid, 1);
    check("n1_e00", elem(0, 0), 8'd7);
    check("n1_e01_cleared", elem(0, 1), 8'd0);
    check("n1_size", matrix_size, 1);
    idle_cycle();

    // Abort coinciding with the last beat drops it
    do_start(8'sd1);
    abort = 1'b1;
    beat(8'sd9);
    abort = 1'b0;
    check("abort_last_no_done", done, 0);
    check("abort_last_valid", matrix_valid, 0);
    check("abort_last_idle", busy, 0);
    check("abort_last_dropped", elem(0, 0), 8'd0);

    // Reset in the middle of a 4x4 load
    do_start(8'sd4);
    for (int i = 0; i < 6; i++) beat(8'(i + 1));
    check("rstmid_pre_count", count, 6);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_ready", in_ready, 0);
    check("rstmid_count", count, 0);
    check("rstmid_size", matrix_size, 0);
    check("rstmid_matrix_zero", matrix == '0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    do_start(8'sd2);
    beat(8'sd1); beat(8'sd2); beat(8'sd3); beat(8'sd4);
    check("rstmid_reload_done", done, 1);
    check("rstmid_reload_det", det2(), -2);
    idle_cycle();

    // start held during a 2x2 load is ignored
    do_start(8'sd2);
    start = 1'b1;
    size  = 8'sd5;
    beat(8'sd5); beat(8'sd6); beat(8'sd7); beat(8'sd8);
    start = 1'b0;
    check("busy_start_done", done, 1);
    check("busy_start_size", matrix_size, 2);
    check("busy_start_count", count, 4);
    check("busy_start_det", det2(), -2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
